// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares one byte-FIFO write port among NUM_REQ packet
// sources. Round-robin between packets, never inside one; an owner that
// stops presenting data for IDLE_TIMEOUT cycles loses the port.
//
// state | meaning
// IDLE  | no owner; pick the next valid requester after rr_ptr (no byte taken)
// XFER  | owner streams bytes into the FIFO until its last byte or a stall timeout
module fifo_wr_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        abort,
    output logic                      busy,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_din
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    // Stall count at which one more idle cycle means timeout.
    localparam logic [CNT_W-1:0] STALL_TC = CNT_W'(IDLE_TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [CNT_W-1:0]   stall_q, stall_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand;
    logic               owner_valid;
    logic               owner_last;
    logic               xfer;

    // Round-robin search: first valid requester after rr_q, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(rr_q) + i) % NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state and output decode; reset gates every strobe that could move data.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        stall_d     = stall_q;
        req_ready   = '0;
        grant       = '0;
        abort       = '0;
        busy        = 1'b0;
        fifo_wr_en  = 1'b0;
        fifo_din    = '0;
        owner_valid = req_valid[owner_q];
        owner_last  = req_last[owner_q];
        xfer        = 1'b0;

        case (state_q)
            IDLE: begin
                stall_d = '0;
                if (win_found) begin
                    state_d = XFER;
                    owner_d = win_idx;
                end
            end
            XFER: begin
                busy               = 1'b1;
                grant[owner_q]     = 1'b1;
                req_ready[owner_q] = !fifo_full && !rst;
                xfer               = owner_valid && !fifo_full && !rst;
                fifo_wr_en         = xfer;
                fifo_din           = req_data[int'(owner_q)*DATA_W +: DATA_W];
                if (xfer) begin
                    stall_d = '0;
                    if (owner_last) begin
                        state_d = IDLE;
                        rr_d    = owner_q;
                    end
                end else if (!owner_valid) begin
                    if (stall_q == STALL_TC) begin
                        abort[owner_q] = !rst;
                        state_d        = IDLE;
                        rr_d           = owner_q;
                        stall_d        = '0;
                    end else begin
                        stall_d = stall_q + CNT_W'(1);
                    end
                end
                // Valid but FIFO full: hold the stall count, backpressure never times out.
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset leaves requester 0 first in line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= LAST_IDX;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios plus randomized packet traffic,
// every cycle compared against a behavioural model of the arbiter.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    typedef struct packed {
        logic [7:0] gap;
        logic       last;
        logic [7:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_last;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  grant;
    logic [N-1:0]  abort;
    logic          busy;
    logic          fifo_full;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_din;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .IDLE_TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .grant      (grant),
        .abort      (abort),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din)
    );

    always #5 clk = ~clk;

    int n_vec   = 0;
    int n_err   = 0;
    int n_abort = 0;

    // Model: owner index (-1 = nobody), last served index, consecutive quiet cycles.
    int m_own   = -1;
    int m_rr    = N - 1;
    int m_quiet = 0;
    bit m_known = 1'b0;

    ent_t         pq[N][$];
    logic [N-1:0] acc;
    logic [N-1:0] ab;
    logic [N-1:0] prev_gnt = '0;
    logic [7:0]   wr_log[$];
    logic [7:0]   gnt_log[$];
    logic [7:0]   exp_q[$];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_q(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
        chk_eq({tag, "_len"}, got.size(), exp.size());
        if (got.size() == exp.size())
            for (int i = 0; i < got.size(); i++) chk_eq(tag, got[i], exp[i]);
    endtask

    task automatic put(input int i, input int gap, input bit last, input logic [7:0] d);
        ent_t e;
        e.gap  = 8'(gap);
        e.last = last;
        e.data = d;
        pq[i].push_back(e);
    endtask

    function automatic int pending();
        int s = 0;
        for (int i = 0; i < N; i++) s += pq[i].size();
        return s;
    endfunction

    // Present each requester's head byte unless it is inside an idle gap.
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (pq[i].size() > 0 && pq[i][0].gap == 8'd0) begin
                req_valid[i]         = 1'b1;
                req_last[i]          = pq[i][0].last;
                req_data[i*DW +: DW] = pq[i][0].data;
            end else begin
                req_valid[i]         = 1'b0;
                req_last[i]          = 1'($urandom_range(0, 1));
                req_data[i*DW +: DW] = 8'($urandom);
            end
        end
    endtask

    // Compare DUT against model at the negedge, then advance the model.
    task automatic cyc();
        logic [N-1:0] e_gnt, e_rdy, e_abt;
        logic         e_wr;
        logic [1:0]   oi;
        bit           found;
        int           c;
        int           gi;
        @(negedge clk);
        oi    = 2'(m_own);
        e_gnt = '0;
        e_rdy = '0;
        e_abt = '0;
        e_wr  = 1'b0;
        if (m_own >= 0) e_gnt = N'(1 << m_own);
        if (!rst && m_own >= 0) begin
            if (!fifo_full) e_rdy = e_gnt;
            e_wr = req_valid[oi] & ~fifo_full;
            if (!req_valid[oi] && (m_quiet + 1 == TO)) e_abt = e_gnt;
        end
        if (m_known) begin
            chk_eq("grant", grant, e_gnt);
            chk_eq("busy", busy, m_own >= 0);
        end
        chk_eq("req_ready", req_ready, e_rdy);
        chk_eq("fifo_wr_en", fifo_wr_en, e_wr);
        chk_eq("abort", abort, e_abt);
        if (e_wr) chk_eq("fifo_din", fifo_din, req_data[oi*DW +: DW]);

        if (fifo_wr_en === 1'b1) wr_log.push_back(fifo_din);
        if (grant != prev_gnt && grant != '0) begin
            gi = 0;
            for (int i = 0; i < N; i++) if (grant[i]) gi = i;
            gnt_log.push_back(8'(gi));
        end
        prev_gnt = grant;
        acc = req_valid & req_ready;
        ab  = abort;
        if (abort != '0) n_abort++;

        if (rst) begin
            m_own   = -1;
            m_rr    = N - 1;
            m_quiet = 0;
            m_known = 1'b1;
        end else if (m_own < 0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                c = (m_rr + k) % N;
                if (!found && req_valid[2'(c)]) begin
                    found   = 1'b1;
                    m_own   = c;
                    m_quiet = 0;
                end
            end
        end else if (e_wr) begin
            m_quiet = 0;
            if (req_last[oi]) begin
                m_rr  = m_own;
                m_own = -1;
            end
        end else if (!req_valid[oi]) begin
            m_quiet++;
            if (m_quiet == TO) begin
                m_rr    = m_own;
                m_own   = -1;
                m_quiet = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Requesters consume accepted bytes, drop the rest of an aborted packet, count down gaps.
    task automatic advance();
        ent_t e;
        bit   done;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                void'(pq[i].pop_front());
            end else if (ab[i]) begin
                done = 1'b0;
                while (!done && pq[i].size() > 0) begin
                    e    = pq[i].pop_front();
                    done = e.last;
                end
            end else if (pq[i].size() > 0 && pq[i][0].gap != 8'd0) begin
                e       = pq[i][0];
                e.gap   = e.gap - 8'd1;
                pq[i][0] = e;
            end
        end
    endtask

    task automatic step();
        drive();
        cyc();
        advance();
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) pq[i].delete();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk_eq("rst_grant", grant, 0);
        chk_eq("rst_busy", busy, 0);
        wr_log.delete();
        gnt_log.delete();
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (pending() > 0 && n < bound) begin
            step();
            n++;
        end
        chk_eq("drain_done", pending(), 0);
        step();
    endtask

    function automatic int pick_gap();
        int r = $urandom_range(0, 39);
        if (r < 30) return 0;
        if (r < 36) return $urandom_range(1, 3);
        if (r == 36) return TO - 1;
        if (r == 37) return TO;
        return TO + 4;
    endfunction

    initial begin
        int nb, na, len;
        rst       = 1'b1;
        fifo_full = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;

        // Three-byte packet from requester 0.
        do_reset();
        put(0, 0, 0, 8'h11); put(0, 0, 0, 8'h22); put(0, 0, 1, 8'h33);
        drain(20);
        exp_q = {8'h11, 8'h22, 8'h33}; chk_q("t1_data", wr_log, exp_q);
        exp_q = {8'd0};                chk_q("t1_grant", gnt_log, exp_q);

        // All four requesters with single-byte packets at once.
        do_reset();
        for (int i = 0; i < N; i++) put(i, 0, 1, 8'(8'hA0 + i));
        drain(30);
        exp_q = {8'hA0, 8'hA1, 8'hA2, 8'hA3}; chk_q("t2_data", wr_log, exp_q);
        exp_q = {8'd0, 8'd1, 8'd2, 8'd3};     chk_q("t2_grant", gnt_log, exp_q);

        // Packet atomicity and fairness: req2 waits for req1, then beats req1's next packet.
        do_reset();
        put(1, 0, 0, 8'h51); put(1, 0, 0, 8'h52); put(1, 0, 1, 8'h53); put(1, 0, 1, 8'h54);
        step(); step();
        put(2, 0, 1, 8'h61);
        drain(40);
        exp_q = {8'h51, 8'h52, 8'h53, 8'h61, 8'h54}; chk_q("t3_data", wr_log, exp_q);
        exp_q = {8'd1, 8'd2, 8'd1};                  chk_q("t3_grant", gnt_log, exp_q);

        // Long FIFO backpressure never aborts and releases the held byte immediately.
        do_reset();
        put(0, 0, 0, 8'h71); put(0, 0, 0, 8'h72); put(0, 0, 1, 8'h73);
        step(); step();
        fifo_full = 1'b1;
        nb = wr_log.size();
        na = n_abort;
        repeat (40) step();
        chk_eq("t4_no_wr", wr_log.size() - nb, 0);
        chk_eq("t4_no_abort", n_abort - na, 0);
        fifo_full = 1'b0;
        drain(20);
        exp_q = {8'h71, 8'h72, 8'h73}; chk_q("t4_data", wr_log, exp_q);

        // Owner goes quiet for the full timeout; next requester takes over.
        do_reset();
        put(3, 0, 0, 8'h81); put(3, TO, 0, 8'h82); put(3, 0, 1, 8'h83);
        step(); step(); step();
        put(1, 0, 1, 8'h91);
        na = n_abort;
        drain(60);
        chk_eq("t5_abort_cnt", n_abort - na, 1);
        exp_q = {8'h81, 8'h91}; chk_q("t5_data", wr_log, exp_q);
        exp_q = {8'd3, 8'd1};   chk_q("t5_grant", gnt_log, exp_q);

        // Reset in the middle of a packet.
        do_reset();
        put(2, 0, 0, 8'hC1); put(2, 0, 0, 8'hC2); put(2, 0, 1, 8'hC3);
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_eq("t6_rst_no_wr", wr_log.size(), 1);
        put(0, 0, 1, 8'hB1);
        na = n_abort;
        drain(30);
        chk_eq("t6_no_abort", n_abort - na, 0);
        exp_q = {8'hC1, 8'hB1, 8'hC2, 8'hC3}; chk_q("t6_data", wr_log, exp_q);
        exp_q = {8'd2, 8'd0, 8'd2};           chk_q("t6_grant", gnt_log, exp_q);

        // Random traffic: packet lengths, gaps around the timeout, backpressure, resets.
        do_reset();
        for (int t = 0; t < 4000; t++) begin
            for (int i = 0; i < N; i++) begin
                if (pq[i].size() == 0 && $urandom_range(0, 3) == 0) begin
                    len = $urandom_range(1, 5);
                    for (int b = 0; b < len; b++)
                        put(i, (b == 0) ? 0 : pick_gap(), b == len - 1, 8'($urandom));
                end
            end
            if ($urandom_range(0, 9) == 0) fifo_full = ~fifo_full;
            rst = ($urandom_range(0, 599) == 0);
            step();
            if (wr_log.size() > 64) wr_log.delete();
            if (gnt_log.size() > 64) gnt_log.delete();
        end
        rst       = 1'b0;
        fifo_full = 1'b0;
        drain(2000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
